// File: rtl/route_pkg.sv
// Shared constants and helpers for the 1-to-4 word distributor.
package route_pkg;
    localparam int ROUTE_NCH   = 4;
    localparam int ROUTE_SEL_W = 2;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/route_fifo.sv
// Single-clock synchronous FIFO; head word read directly from the storage array.
module route_fifo
    import route_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      empty,
    output logic                      full,
    output logic [occ_w(DEPTH)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Refuse writes when full even if a pop lands on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;
endmodule

// File: rtl/route1_4_8b.sv
// Buffered 1-to-4 distributor: steers one valid/ready stream into four channel FIFOs.
// Optional broadcast-to-all-channels input enabled by defining ROUTE_BCAST_EN.
module route1_4_8b
    import route_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    in_data,
    input  logic [ROUTE_SEL_W-1:0]              in_sel,
`ifdef ROUTE_BCAST_EN
    input  logic                                in_bcast,
`endif
    output logic [ROUTE_NCH-1:0]                out_valid,
    input  logic [ROUTE_NCH-1:0]                out_ready,
    output logic [ROUTE_NCH*WIDTH-1:0]          out_data,
    output logic [ROUTE_NCH*occ_w(DEPTH)-1:0]   out_count
);
    localparam int CW = occ_w(DEPTH);

    logic [ROUTE_NCH-1:0] full;
    logic [ROUTE_NCH-1:0] empty;
    logic [ROUTE_NCH-1:0] push;
    logic                 accept;

    // Readiness depends only on enable, select and registered full flags.
`ifdef ROUTE_BCAST_EN
    assign in_ready = ~rst & en & (in_bcast ? ~(|full) : ~full[in_sel]);
`else
    assign in_ready = ~rst & en & ~full[in_sel];
`endif

    assign accept = in_valid & in_ready;

    for (genvar k = 0; k < ROUTE_NCH; k++) begin : g_ch
`ifdef ROUTE_BCAST_EN
        assign push[k] = accept & (in_bcast | (in_sel == ROUTE_SEL_W'(k)));
`else
        assign push[k] = accept & (in_sel == ROUTE_SEL_W'(k));
`endif

        route_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .pop   (out_ready[k]),
            .wdata (in_data),
            .rdata (out_data[k*WIDTH +: WIDTH]),
            .empty (empty[k]),
            .full  (full[k]),
            .count (out_count[k*CW +: CW])
        );

        assign out_valid[k] = ~empty[k];
    end
endmodule

// File: tb/tb_route1_4_8b.sv
// Self-checking bench for route1_4_8b against a per-channel queue model.
module tb_route1_4_8b;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [11:0] out_count;
    logic        bc = 1'b0;
`ifdef ROUTE_BCAST_EN
    wire         in_bcast;
    assign in_bcast = bc;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] q [4][$];

    route1_4_8b #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
`ifdef ROUTE_BCAST_EN
        .in_bcast  (in_bcast),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic model_ready();
        logic any_full = 1'b0;
        for (int k = 0; k < 4; k++) if (q[k].size() >= DEPTH) any_full = 1'b1;
        if (!en) return 1'b0;
        if (bc) return !any_full;
        return q[in_sel].size() < DEPTH;
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(q[k].size() > 0));
            check($sformatf("count%0d", k), 32'(out_count[k*CW +: CW]), 32'(q[k].size()));
            if (q[k].size() > 0)
                check($sformatf("data%0d", k), 32'(out_data[k*8 +: 8]), 32'(q[k][0]));
        end
        check("in_ready", 32'(in_ready), 32'(model_ready()));
    endtask

    task automatic step(input logic e, input logic v, input logic [1:0] s,
                        input logic [7:0] d, input logic [3:0] r);
        logic       acc;
        logic [3:0] pop;
        en = e; in_valid = v; in_sel = s; in_data = d; out_ready = r;
        #1;
        check_outputs();
        acc = v & model_ready();
        for (int k = 0; k < 4; k++) pop[k] = r[k] && (q[k].size() > 0);
        @(posedge clk);
        for (int k = 0; k < 4; k++) if (pop[k]) void'(q[k].pop_front());
        if (acc)
            for (int k = 0; k < 4; k++)
                if (bc || s == 2'(k)) q[k].push_back(d);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b0, 2'd0, 8'h00, 4'hF);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'h0;
        @(negedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_count", 32'(out_count), 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // routing and one-cycle latency
        step(1'b1, 1'b1, 2'd1, 8'hA5, 4'h0);
        check("route_valid", 32'(out_valid), 32'h2);
        check("route_data", 32'(out_data[15:8]), 32'hA5);
        check("route_count", 32'(out_count[5:3]), 32'h1);
        drain();

        // full boundary on ch3
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 2'd3, 8'(i), 4'h0);
        check("full_ready3", 32'(in_ready & (in_sel == 2'd3)), 32'h0);
        step(1'b1, 1'b1, 2'd3, 8'h05, 4'h0);
        check("full_cnt3", 32'(out_count[11:9]), 32'h4);
        step(1'b1, 1'b1, 2'd0, 8'h10, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 32'(out_data[31:24]), 32'(i));
            step(1'b1, 1'b0, 2'd0, 8'h00, 4'h8);
        end
        check("drained3", 32'(out_valid[3]), 32'h0);

        // simultaneous push and pop on ch0, then full with pop pending
        step(1'b1, 1'b1, 2'd0, 8'h11, 4'h0);
        step(1'b1, 1'b1, 2'd0, 8'h12, 4'h1);
        check("pp_count", 32'(out_count[2:0]), 32'h2);
        check("pp_head", 32'(out_data[7:0]), 32'h11);
        step(1'b1, 1'b1, 2'd0, 8'h13, 4'h0);
        step(1'b1, 1'b1, 2'd0, 8'h14, 4'h0);
        step(1'b1, 1'b1, 2'd0, 8'h15, 4'h1);
        check("full_pop_cnt", 32'(out_count[2:0]), 32'h3);
        drain();

        // en=0 blocks input but outputs keep draining
        step(1'b1, 1'b1, 2'd1, 8'h77, 4'h0);
        step(1'b0, 1'b1, 2'd1, 8'h88, 4'h0);
        step(1'b0, 1'b1, 2'd1, 8'h99, 4'h2);
        check("en0_empty", 32'(out_count), 32'h0);

        // reset mid-traffic
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd2, 8'hC0 + 8'(i), 4'h0);
        en = 1'b1; in_valid = 1'b1; in_sel = 2'd2;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_count", 32'(out_count), 32'h0);
        check("mid_rst_ready", 32'(in_ready), 32'h0);
        for (int k = 0; k < 4; k++) q[k].delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd2, 8'h00, 4'hF);

`ifdef ROUTE_BCAST_EN
        bc = 1'b1;
        step(1'b1, 1'b1, 2'd1, 8'h3C, 4'h0);
        check("bc_count", 32'(out_count), {20'h0, 3'd1, 3'd1, 3'd1, 3'd1});
        check("bc_data", out_data, 32'h3C3C3C3C);
        bc = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd2, 8'h40 + 8'(i), 4'h0);
        bc = 1'b1;
        step(1'b1, 1'b1, 2'd0, 8'h55, 4'h0);
        bc = 1'b0;
        step(1'b1, 1'b1, 2'd0, 8'h66, 4'h0);
        check("bc_sel0_cnt", 32'(out_count[2:0]), 32'h2);
        drain();
`endif

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
`ifdef ROUTE_BCAST_EN
            bc = ($urandom_range(0, 7) == 0);
`endif
            step($urandom_range(0, 7) != 0, 1'($urandom), 2'($urandom_range(0, 3)),
                 8'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
        end
        bc = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
